io_beacon_array: RTL and testbench
==================================

Name: io_beacon_array

Overview:
- Multi-channel pin-identification beacon for board bring-up and all-IO test images.
- Each output pin carries its own fixed ASCII name, followed by CR LF, as 8N1 UART once per send interval.
- A single shared baud/interval timer and shift sequencer serves every channel, replacing one UART instance per pin.
- Adds a per-channel enable mask plus idle, toggle and walking-zero modes for short/open detection.

Parameters:
- N_CH, 147, number of output channels.
- NAME_LEN, 4, characters per pin name; CR LF is appended, so each frame is NAME_LEN+2 characters.
- PIN_NAMES, all spaces, packed [N_CH*NAME_LEN*8-1:0]; character k of channel i sits at bits [(i*NAME_LEN+k)*8 +: 8]; k=NAME_LEN-1 is sent first (string-literal order).
- CLK_FRE_HZ, 25_000_000, input clock frequency.
- UART_RATE, 115200, baud rate.
- SEND_FRE_HZ, 1, interval ticks per second.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- mode  in  2  0=IDLE, 1=UART, 2=TOGGLE, 3=WALK; sampled only at an interval tick while the sequencer is in IDLE
- ch_en  in  N_CH  per-channel enable, sampled every cycle; a disabled channel drives 1
- tx  out  N_CH  pin outputs
- busy  out  1  high while a UART frame is being shifted
- frame_done  out  1  one-cycle pulse after the last stop bit of a frame
- walk_idx  out  $clog2(N_CH)  channel currently driven low in WALK mode

Behaviour:
- Derived constants:
  - BAUD_DIV = (CLK_FRE_HZ + UART_RATE/2) / UART_RATE, rounded.
  - INTERVAL = CLK_FRE_HZ / SEND_FRE_HZ.
  - Elaboration error if BAUD_DIV < 2 or INTERVAL < 2.
- Reset: tx all 1, busy 0, frame_done 0, walk_idx 0, latched mode IDLE, toggle register 1, all counters 0.
- Interval counter:
  - Free-running 0..INTERVAL-1.
  - tick_i is asserted in the cycle the count equals INTERVAL-1.
  - The first tick_i after reset occurs INTERVAL cycles after rst deasserts.
- Sequencer states: S_IDLE, S_START, S_DATA, S_STOP.
  - S_IDLE, on tick_i: latch mode into mode_q.
    - If mode_q=UART: char index 0, reset the baud counter, go to S_START.
    - Otherwise: apply the tick action and stay in S_IDLE.
  - A tick_i arriving outside S_IDLE is dropped. No queuing; mode is not re-latched.
  - Each of S_START, S_DATA and S_STOP lasts BAUD_DIV cycles, timed by a baud counter cleared on every state entry.
  - S_START drives 0.
  - S_DATA shifts 8 bits LSB first; the bit counter runs 0..7.
  - S_STOP drives 1.
    - If it is not the last character: advance char index, go to S_START.
    - Else: go to S_IDLE and pulse frame_done for one cycle in the first S_IDLE cycle.
  - Character order: PIN_NAMES bytes k=NAME_LEN-1 down to 0, then 0x0D, then 0x0A (identical on all channels).
  - Frame length: (NAME_LEN+2)*10*BAUD_DIV cycles.
- busy = 1 in S_START/S_DATA/S_STOP, otherwise 0.
- tx[i] is registered (one cycle after state/bit change) and is 1 whenever ch_en[i]=0. When ch_en[i]=1:
  - IDLE: 1.
  - UART: the current line bit of channel i (1 while the sequencer is in S_IDLE).
  - TOGGLE: the toggle register, inverted on each tick_i; it is set to 1 on the tick that latches TOGGLE from another mode.
  - WALK: 0 if i == walk_idx, else 1. walk_idx increments on each tick_i while mode_q=WALK and wraps N_CH-1 -> 0. It is cleared to 0 on the tick that latches WALK from another mode.
- Edge cases:
  - Mode change mid-frame takes effect at the first tick_i after the frame completes.
  - A ch_en change mid-frame takes effect next cycle; a channel disabled mid-frame is glitch-free high.
  - rst mid-frame forces all outputs to 1 immediately (asynchronous); the sequencer restarts from S_IDLE.

Decomposition:
- Package io_beacon_pkg:
  - mode enum (MODE_IDLE, MODE_UART, MODE_TOGGLE, MODE_WALK).
  - sequencer state enum.
  - CHAR_CR=8'h0D, CHAR_LF=8'h0A, FRAME_BITS=10.
- Sub-module beacon_timer, parameters BAUD_DIV and INTERVAL:
  - Outputs tick_i and the baud-done strobe.
  - Accepts a baud-counter clear input.

Test Plan: (CLK_FRE_HZ=1000, UART_RATE=100, SEND_FRE_HZ=1, N_CH=4, NAME_LEN=2, names "A1","B2","C3","D4")
- Reset then mode=UART, ch_en=4'hF -> first start bit at cycle ~1000 after reset release. The UART monitor decodes "A1\r\n" on tx[0] and "D4\r\n" on tx[3], 10 cycles per bit. busy is high for 400 cycles; frame_done pulses once.
- Mode=TOGGLE, ch_en=4'b0101 -> tx[0] and tx[2] invert every 1000 cycles starting from 1; tx[1] and tx[3] stay 1.
- Mode=WALK, ch_en=4'hF -> walk_idx sequence 0,1,2,3,0 on successive ticks; exactly tx[walk_idx]=0.
- Switch UART->WALK at cycle 1200 (mid-frame) -> frame completes unchanged; WALK latched at tick 2000 with walk_idx=0.
- Assert rst at cycle 1150 mid-frame -> tx=4'hF and busy=0 within the same cycle; after release, the next frame starts 1000 cycles later.
- Clear ch_en[1] at cycle 1100 during UART -> tx[1]=1 from cycle 1101 onward; the other channels decode correctly.

Source files
------------

// File: rtl/io_beacon_pkg.sv
// Shared types and constants for the multi-channel pin-identification beacon.
package io_beacon_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_UART   = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_WALK   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } seq_state_e;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam int         FRAME_BITS = 10;

    function automatic int baud_div_calc(input int clk_hz, input int rate);
        return (clk_hz + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/beacon_timer.sv
// Shared timing for the beacon: free-running send-interval tick plus a
// clearable baud counter that strobes once per bit period.
module beacon_timer #(
    parameter int BAUD_DIV = 217,
    parameter int INTERVAL = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_clr,
    output logic tick_i,
    output logic baud_done
);

    localparam int INT_W  = $clog2(INTERVAL);
    localparam int BAUD_W = $clog2(BAUD_DIV);

    if (BAUD_DIV < 2 || INTERVAL < 2) begin : g_param_err
        $error("beacon_timer: BAUD_DIV and INTERVAL must both be at least 2");
    end

    logic [INT_W-1:0]  int_cnt;
    logic [BAUD_W-1:0] baud_cnt;

    assign tick_i    = (int_cnt == INT_W'(INTERVAL - 1));
    assign baud_done = (baud_cnt == BAUD_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_cnt <= '0;
        end else if (tick_i) begin
            int_cnt <= '0;
        end else begin
            int_cnt <= int_cnt + INT_W'(1);
        end
    end

    // Clearing on done as well as on request gives back-to-back bit periods in S_DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (baud_clr || baud_done) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/io_beacon_array.sv
// Multi-channel pin-identification beacon: one shared sequencer sends each
// pin's own name + CR LF as 8N1 UART, or drives idle / toggle / walking-zero.
//
//   state   | meaning
//   S_IDLE  | between frames; interval tick latches mode and runs tick action
//   S_START | start bit (line 0) for the current character
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit (line 1); then next character or back to S_IDLE
module io_beacon_array
    import io_beacon_pkg::*;
#(
    parameter int N_CH        = 147,
    parameter int NAME_LEN    = 4,
    parameter logic [N_CH*NAME_LEN*8-1:0] PIN_NAMES = {(N_CH*NAME_LEN){8'h20}},
    parameter int CLK_FRE_HZ  = 25_000_000,
    parameter int UART_RATE   = 115200,
    parameter int SEND_FRE_HZ = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic [N_CH-1:0]          ch_en,
    output logic [N_CH-1:0]          tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(N_CH)-1:0]  walk_idx
);

    localparam int BAUD_DIV = baud_div_calc(CLK_FRE_HZ, UART_RATE);
    localparam int INTERVAL = CLK_FRE_HZ / SEND_FRE_HZ;
    localparam int CIDX_W   = $clog2(NAME_LEN + 2);
    localparam int WIDX_W   = $clog2(N_CH);

    seq_state_e           state, state_n;
    mode_e                mode_q, mode_n;
    logic [CIDX_W-1:0]    char_idx, char_idx_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic                 tog_q, tog_n;
    logic [WIDX_W-1:0]    walk_n;
    logic                 done_n;
    logic                 baud_clr;
    logic                 tick_i;
    logic                 baud_done;
    logic [N_CH-1:0]      tx_d;

    beacon_timer #(
        .BAUD_DIV (BAUD_DIV),
        .INTERVAL (INTERVAL)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .baud_clr  (baud_clr),
        .tick_i    (tick_i),
        .baud_done (baud_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_q     <= MODE_IDLE;
            char_idx   <= '0;
            bit_idx    <= '0;
            tog_q      <= 1'b1;
            walk_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            char_idx   <= char_idx_n;
            bit_idx    <= bit_idx_n;
            tog_q      <= tog_n;
            walk_idx   <= walk_n;
            frame_done <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        mode_n     = mode_q;
        char_idx_n = char_idx;
        bit_idx_n  = bit_idx;
        tog_n      = tog_q;
        walk_n     = walk_idx;
        done_n     = 1'b0;
        baud_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                baud_clr = 1'b1;
                if (tick_i) begin
                    mode_n = mode_e'(mode);
                    case (mode_e'(mode))
                        MODE_UART: begin
                            state_n    = S_START;
                            char_idx_n = '0;
                        end
                        // Entering toggle/walk from another mode restarts the pattern.
                        MODE_TOGGLE: tog_n = (mode_q == MODE_TOGGLE) ? ~tog_q : 1'b1;
                        MODE_WALK: begin
                            if (mode_q != MODE_WALK || walk_idx == WIDX_W'(N_CH - 1)) begin
                                walk_n = '0;
                            end else begin
                                walk_n = walk_idx + WIDX_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_n   = S_DATA;
                    bit_idx_n = '0;
                    baud_clr  = 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'd7) begin
                        state_n  = S_STOP;
                        baud_clr = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    baud_clr = 1'b1;
                    if (char_idx == CIDX_W'(NAME_LEN + 1)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = S_START;
                        char_idx_n = char_idx + CIDX_W'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [2**CIDX_W-1:0][7:0] fchars;
        logic                      line_bit;
        logic                      pin_val;

        // Frame character table in send order; name bytes go highest first.
        for (genvar k = 0; k < 2**CIDX_W; k++) begin : g_chr
            if (k < NAME_LEN) begin : g_name
                assign fchars[k] = PIN_NAMES[(i*NAME_LEN + NAME_LEN - 1 - k)*8 +: 8];
            end else if (k == NAME_LEN) begin : g_cr
                assign fchars[k] = CHAR_CR;
            end else if (k == NAME_LEN + 1) begin : g_lf
                assign fchars[k] = CHAR_LF;
            end else begin : g_pad
                assign fchars[k] = 8'hFF;
            end
        end

        always_comb begin
            line_bit = 1'b1;
            if (state == S_START) begin
                line_bit = 1'b0;
            end else if (state == S_DATA) begin
                line_bit = fchars[char_idx][bit_idx];
            end
            case (mode_q)
                MODE_UART:   pin_val = line_bit;
                MODE_TOGGLE: pin_val = tog_q;
                MODE_WALK:   pin_val = (walk_idx != WIDX_W'(i));
                default:     pin_val = 1'b1;
            endcase
        end

        assign tx_d[i] = ~ch_en[i] | pin_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx <= '1;
        end else begin
            tx <= tx_d;
        end
    end

endmodule

// File: tb/tb_io_beacon_array.sv
// Bench for io_beacon_array: directed scenarios plus randomized mode/enable
// traffic, checked every cycle against a cycle-level behavioural model.
module tb_io_beacon_array;

    localparam int N_CH      = 4;
    localparam int NAME_LEN  = 2;
    localparam int BD        = 10;
    localparam int INTERVAL  = 1000;
    localparam int FRAME_CYC = (NAME_LEN + 2) * 10 * BD;

    localparam logic [1:0] M_IDLE   = 2'd0;
    localparam logic [1:0] M_UART   = 2'd1;
    localparam logic [1:0] M_TOGGLE = 2'd2;
    localparam logic [1:0] M_WALK   = 2'd3;

    localparam logic [15:0] NAMES [4] = '{"A1", "B2", "C3", "D4"};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode = M_IDLE;
    logic [N_CH-1:0]  ch_en = '1;
    logic [N_CH-1:0]  tx;
    logic             busy;
    logic             frame_done;
    logic [1:0]       walk_idx;

    int checks = 0;
    int errors = 0;

    io_beacon_array #(
        .N_CH        (N_CH),
        .NAME_LEN    (NAME_LEN),
        .PIN_NAMES   ({"D4", "C3", "B2", "A1"}),
        .CLK_FRE_HZ  (1000),
        .UART_RATE   (100),
        .SEND_FRE_HZ (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .ch_en      (ch_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .walk_idx   (walk_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_char(input int ch, input int ci);
        logic [15:0] nm;
        logic [7:0]  r;
        nm = NAMES[ch];
        if (ci < NAME_LEN)       r = nm[15 - 8*ci -: 8];
        else if (ci == NAME_LEN) r = 8'h0D;
        else                     r = 8'h0A;
        return r;
    endfunction

    // Model: n = clock edges since reset release, F = edge at which the frame began.
    int          n = 0;
    bit          hf = 1'b0;
    int          F = 0;
    logic [1:0]  m_mode = M_IDLE;
    bit          m_tog = 1'b1;
    int          m_walk = 0;
    bit          m_idle;
    logic [3:0]  exp_tx = '1;

    function automatic logic model_pin(input int i, input bit idle, input int off);
        logic       r;
        logic [7:0] c;
        int         ci, bi;
        r = 1'b1;
        case (m_mode)
            M_UART: begin
                if (!idle) begin
                    ci = off / (10 * BD);
                    bi = (off % (10 * BD)) / BD;
                    c  = exp_char(i, ci);
                    if (bi == 0)      r = 1'b0;
                    else if (bi == 9) r = 1'b1;
                    else              r = c[bi-1];
                end
            end
            M_TOGGLE: r = m_tog;
            M_WALK:   r = (i != m_walk);
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            n = 0; hf = 1'b0; F = 0;
            m_mode = M_IDLE; m_tog = 1'b1; m_walk = 0;
            exp_tx = '1;
        end else begin
            m_idle = !(hf && n >= F && n < F + FRAME_CYC);
            for (int i = 0; i < N_CH; i++) begin
                exp_tx[i] = !ch_en[i] | model_pin(i, m_idle, n - F);
            end
            n++;
            if (n % INTERVAL == 0 && m_idle) begin
                case (mode)
                    M_UART:   begin hf = 1'b1; F = n; end
                    M_TOGGLE: m_tog = (m_mode == M_TOGGLE) ? !m_tog : 1'b1;
                    M_WALK:   m_walk = (m_mode == M_WALK) ? (m_walk + 1) % N_CH : 0;
                    default: ;
                endcase
                m_mode = mode;
            end
        end
    end

    // UART receiver on every pin: 10 cycles per bit, sampled mid-bit.
    int         mon_cnt [4];
    logic [7:0] mon_sh  [4];
    logic [7:0] rx_log  [4][256];
    int         rx_cnt  [4];

    always @(negedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                mon_cnt[i] = 0;
            end else if (mon_cnt[i] == 0) begin
                if (tx[i] === 1'b0) mon_cnt[i] = 1;
            end else begin
                mon_cnt[i]++;
                if (mon_cnt[i] >= 16 && mon_cnt[i] <= 86 && (mon_cnt[i] - 16) % 10 == 0) begin
                    mon_sh[i] = {tx[i], mon_sh[i][7:1]};
                end
                if (mon_cnt[i] == 96) begin
                    if (rx_cnt[i] < 256) rx_log[i][rx_cnt[i]] = mon_sh[i];
                    rx_cnt[i]++;
                    mon_cnt[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic cycle_check();
        logic [3:0] e_tx;
        logic       e_busy, e_done;
        logic [1:0] e_walk;
        e_tx   = rst ? 4'hF : exp_tx;
        e_busy = !rst && hf && n >= F && n < F + FRAME_CYC;
        e_done = !rst && hf && n == F + FRAME_CYC;
        e_walk = rst ? 2'd0 : 2'(m_walk);
        chk("cyc_tx", 32'(tx), 32'(e_tx));
        chk("cyc_busy", 32'(busy), 32'(e_busy));
        chk("cyc_frame_done", 32'(frame_done), 32'(e_done));
        chk("cyc_walk_idx", 32'(walk_idx), 32'(e_walk));
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string tag);
        for (int k = 0; k < lim && busy !== lvl; k++) @(negedge clk);
        chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_tick();
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (n % INTERVAL == 0) break;
        end
    endtask

    task automatic check_rx(input int ch, input int b0);
        chk($sformatf("rx%0d_count", ch), 32'(rx_cnt[ch] - b0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (b0 + k < 256) chk($sformatf("rx%0d_char%0d", ch, k), 32'(rx_log[ch][b0+k]), 32'(exp_char(ch, k)));
        end
    endtask

    initial begin
        int         base [4];
        int         bcnt, dcnt;
        logic [1:0] wseq [5];
        logic       tg;

        fork
            forever begin
                @(negedge clk);
                cycle_check();
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_walk_idx", 32'(walk_idx), 32'd0);

        // First UART frame on all channels
        mode = M_UART;
        ch_en = 4'hF;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) base[i] = rx_cnt[i];
        wait_busy(1'b1, 1100, "b_busy_rise");
        chk("b_first_start_n", 32'(n), 32'(INTERVAL));
        bcnt = 0; dcnt = 0;
        for (int k = 0; k < 600 && busy === 1'b1; k++) begin
            bcnt++;
            @(negedge clk);
            if (frame_done === 1'b1) dcnt++;
        end
        repeat (20) begin
            @(negedge clk);
            if (frame_done === 1'b1) dcnt++;
        end
        chk("b_busy_cycles", 32'(bcnt), 32'(FRAME_CYC));
        chk("b_frame_done_pulses", 32'(dcnt), 32'd1);
        for (int i = 0; i < 4; i++) check_rx(i, base[i]);

        // Disable channel 1 part-way through a frame
        for (int i = 0; i < 4; i++) base[i] = rx_cnt[i];
        wait_busy(1'b1, 1100, "c_busy_rise");
        repeat (100) @(negedge clk);
        ch_en = 4'b1101;
        wait_busy(1'b0, 500, "c_busy_fall");
        repeat (20) @(negedge clk);
        check_rx(0, base[0]);
        check_rx(2, base[2]);
        check_rx(3, base[3]);
        ch_en = 4'hF;

        // UART -> WALK requested mid-frame
        wait_busy(1'b1, 1100, "d_busy_rise");
        for (int i = 0; i < 4; i++) base[i] = rx_cnt[i];
        repeat (200) @(negedge clk);
        mode = M_WALK;
        wait_busy(1'b0, 500, "d_busy_fall");
        repeat (20) @(negedge clk);
        check_rx(2, base[2]);
        wseq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int j = 0; j < 5; j++) begin
            wait_tick();
            @(negedge clk);
            chk("walk_idx_seq", 32'(walk_idx), 32'(wseq[j]));
            chk("walk_tx", 32'(tx), 32'(4'hF & ~(4'b0001 << wseq[j])));
        end

        // TOGGLE on channels 0 and 2 only
        mode = M_TOGGLE;
        ch_en = 4'b0101;
        tg = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_tick();
            @(negedge clk);
            chk("toggle_tx", 32'(tx), 32'({1'b1, tg, 1'b1, tg}));
            tg = ~tg;
        end

        // Randomized modes and enables
        for (int r = 0; r < 10; r++) begin
            mode = 2'($urandom_range(0, 3));
            repeat (8) begin
                repeat ($urandom_range(20, 150)) @(negedge clk);
                ch_en = 4'($urandom);
            end
        end

        // Reset mid-frame
        mode = M_UART;
        ch_en = 4'hF;
        wait_busy(1'b0, 500, "g_idle");
        wait_busy(1'b1, 1100, "g_busy_rise");
        repeat (150) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("g_rst_tx", 32'(tx), 32'hF);
        chk("g_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_busy(1'b1, 1100, "g_restart_rise");
        chk("g_restart_n", 32'(n), 32'(INTERVAL));
        wait_busy(1'b0, 500, "g_restart_fall");
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
